// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: pipelined Rijndael ShiftRows/InvShiftRows for 4xNB byte states with valid/ready flow control.
// Optional byte-parity checking is built when SHIFT_ROWS_PARITY_EN is defined.
module shift_rows_pipe #(
    parameter int NB         = 4,
    parameter int PIPE_DEPTH = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_inv,
    input  logic [32*NB-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [32*NB-1:0] out_data
`ifdef SHIFT_ROWS_PARITY_EN
    ,
    input  logic [4*NB-1:0] in_par,
    output logic [4*NB-1:0] out_par,
    output logic            par_err
`endif
);

    localparam int W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
        $error("shift_rows_pipe: PIPE_DEPTH must be 1..4");
    end

    // Row offsets: {0,1,2,3}, except 256-bit blocks use {0,1,3,4}.
    function automatic int off(input int r);
        return (NB == 8 && r > 1) ? r + 1 : r;
    endfunction

    function automatic int src(input int r, input int c, input logic inv);
        return inv ? (c + NB - off(r)) % NB : (c + off(r)) % NB;
    endfunction

    logic [W-1:0]          perm_data;
    logic [PIPE_DEPTH:0]   rdy;
    logic [PIPE_DEPTH:0]   v_s;
    logic [PIPE_DEPTH-1:0] v_q;
    logic [PIPE_DEPTH-1:0] v_d;
    logic [PIPE_DEPTH-1:0] ld;
    logic [W-1:0]          data_s [PIPE_DEPTH+1];
    logic [W-1:0]          data_q [PIPE_DEPTH];

    always_comb begin
        perm_data = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < NB; c++)
                perm_data[8*(r+4*c) +: 8] = in_data[8*(r+4*src(r, c, in_inv)) +: 8];
    end

    // Ready ripples back from the output: a stage can load if empty or draining.
    always_comb begin
        rdy[PIPE_DEPTH] = out_ready;
        for (int i = PIPE_DEPTH - 1; i >= 0; i--)
            rdy[i] = !v_q[i] || rdy[i+1];
        v_s       = {v_q, in_valid};
        data_s[0] = perm_data;
        for (int i = 0; i < PIPE_DEPTH; i++)
            data_s[i+1] = data_q[i];
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            v_d[i] = rdy[i] ? v_s[i] : v_q[i];
            ld[i]  = rdy[i] && v_s[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++)
                data_q[i] <= '0;
        end else begin
            v_q <= v_d;
            for (int i = 0; i < PIPE_DEPTH; i++)
                if (ld[i])
                    data_q[i] <= data_s[i];
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[PIPE_DEPTH-1];
    assign out_data  = data_q[PIPE_DEPTH-1];

`ifdef SHIFT_ROWS_PARITY_EN
    logic [4*NB-1:0] perm_par;
    logic [4*NB-1:0] par_calc;
    logic [4*NB-1:0] par_s [PIPE_DEPTH+1];
    logic [4*NB-1:0] par_q [PIPE_DEPTH];
    logic            par_err_q;
    logic            par_err_d;

    always_comb begin
        perm_par = '0;
        par_calc = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < NB; c++)
                perm_par[r+4*c] = in_par[r+4*src(r, c, in_inv)];
        for (int i = 0; i < 4 * NB; i++)
            par_calc[i] = ^in_data[8*i +: 8];
        par_s[0] = perm_par;
        for (int i = 0; i < PIPE_DEPTH; i++)
            par_s[i+1] = par_q[i];
        par_err_d = par_err_q || (in_valid && in_ready && (par_calc != in_par));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
            for (int i = 0; i < PIPE_DEPTH; i++)
                par_q[i] <= '0;
        end else begin
            par_err_q <= par_err_d;
            for (int i = 0; i < PIPE_DEPTH; i++)
                if (ld[i])
                    par_q[i] <= par_s[i];
        end
    end

    assign out_par = par_q[PIPE_DEPTH-1];
    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: directed checks of shift_rows_pipe (NB=4 depth 3, NB=8 depth 1), incl. flow control and reset.
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         a_in_valid = 1'b0, a_in_ready, a_in_inv = 1'b0, a_out_valid, a_out_ready = 1'b1;
    logic [127:0] a_in_data = '0, a_out_data;
    logic         b_in_valid = 1'b0, b_in_ready, b_in_inv = 1'b0, b_out_valid, b_out_ready = 1'b1;
    logic [255:0] b_in_data = '0, b_out_data;
    logic [15:0]  a_flip = '0;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] par(input logic [255:0] d, input int nb);
        logic [31:0] p = '0;
        for (int i = 0; i < 4 * nb; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    function automatic logic [255:0] model(input logic [255:0] d, input bit inv, input int nb);
        logic [255:0] m = '0;
        int k, s;
        for (int j = 0; j < 4 * nb; j++) begin
            case (j % 4)
                0: k = 0;
                1: k = 1;
                2: k = (nb == 8) ? 3 : 2;
                default: k = (nb == 8) ? 4 : 3;
            endcase
            s = inv ? (j / 4 - k + nb) % nb : (j / 4 + k) % nb;
            m[8*j +: 8] = d[8*((j % 4) + 4*s) +: 8];
        end
        return m;
    endfunction

`ifdef SHIFT_ROWS_PARITY_EN
    logic [15:0] a_in_par, a_out_par;
    logic [31:0] b_in_par, b_out_par;
    logic        a_par_err, b_par_err;
    logic [31:0] a_par_full;
    assign a_par_full = par({128'h0, a_in_data}, 4);
    assign a_in_par = a_par_full[15:0] ^ a_flip;
    assign b_in_par = par(b_in_data, 8);
`endif

    shift_rows_pipe #(.NB(4), .PIPE_DEPTH(3)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
`ifdef SHIFT_ROWS_PARITY_EN
        , .in_par(a_in_par), .out_par(a_out_par), .par_err(a_par_err)
`endif
    );

    shift_rows_pipe #(.NB(8), .PIPE_DEPTH(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef SHIFT_ROWS_PARITY_EN
        , .in_par(b_in_par), .out_par(b_out_par), .par_err(b_par_err)
`endif
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated block through dut_a: accepted on the first edge, visible after the third.
    task automatic send_a(input logic [127:0] d, input bit inv, input logic [15:0] flip, input logic [127:0] exp);
        a_flip = flip;
        a_in_valid = 1'b1;
        a_in_data = d;
        a_in_inv = inv;
        @(negedge clk) chk("a_in_ready", a_in_ready, 1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_flip = '0;
        @(negedge clk) chk("a_out_valid_early", a_out_valid, 0);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("a_out_valid_lat", a_out_valid, 1);
        chk("a_out_data", a_out_data, exp);
`ifdef SHIFT_ROWS_PARITY_EN
        if (flip == 0) chk("a_out_par", a_out_par, par({128'h0, exp}, 4));
`endif
        @(posedge clk); #1;
    endtask

    logic [127:0] blk [8];
    logic [127:0] expq [$];
    logic [127:0] hold;
    logic [255:0] seq8;
    bit held;
    int sent, got, occ, cyc;

    initial begin
        #3;
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_a_data", a_out_data, 0);
        chk("rst_b_valid", b_out_valid, 0);
        chk("rst_b_data", b_out_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rel_a_ready", a_in_ready, 1);
        chk("rel_b_ready", b_in_ready, 1);
        @(posedge clk); #1;

        send_a(128'h3052411ee55db4b8f198bfe0ae1127d4, 0, '0, 128'he598271ef11141b8ae52b4e0305dbfd4);
        send_a(128'he598271ef11141b8ae52b4e0305dbfd4, 1, '0, 128'h3052411ee55db4b8f198bfe0ae1127d4);

        for (int i = 0; i < 32; i++) seq8[8*i +: 8] = 8'(i);
        b_in_valid = 1'b1; b_in_data = seq8; b_in_inv = 1'b0;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_fwd_valid", b_out_valid, 1);
        chk("b_fwd_byte1", b_out_data[15:8], 8'h05);
        chk("b_fwd_byte2", b_out_data[23:16], 8'h0e);
        chk("b_fwd_byte3", b_out_data[31:24], 8'h13);
        chk("b_fwd_byte31", b_out_data[255:248], 8'h0f);
        chk("b_fwd_all", b_out_data, model(seq8, 0, 8));
        @(posedge clk); #1;
        b_in_valid = 1'b1; b_in_inv = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b_inv_byte1", b_out_data[15:8], 8'h1d);
        chk("b_inv_byte2", b_out_data[23:16], 8'h16);
        chk("b_inv_byte3", b_out_data[31:24], 8'h13);
        chk("b_inv_all", b_out_data, model(seq8, 1, 8));
        @(posedge clk); #1;

        // Stream of 8 mixed-direction blocks under back-pressure.
        for (int i = 0; i < 8; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
        sent = 0; got = 0; occ = 0; held = 0;
        for (cyc = 0; cyc < 300 && got < 8; cyc++) begin
            a_in_valid = (sent < 8);
            a_in_data = blk[sent % 8];
            a_in_inv = sent[0];
            a_out_ready = (cyc < 5) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (held) begin
                chk("stall_valid", a_out_valid, 1);
                chk("stall_data", a_out_data, hold);
            end
            chk("stream_ready", a_in_ready, !(occ == 3 && !a_out_ready));
            held = a_out_valid && !a_out_ready;
            hold = a_out_data;
            if (a_out_valid && a_out_ready) begin
                chk("stream_data", a_out_data, expq.pop_front());
                got++;
                occ--;
            end
            if (a_in_valid && a_in_ready) begin
                expq.push_back(model({128'h0, blk[sent]}, sent[0], 4));
                sent++;
                occ++;
            end
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        chk("stream_count", got, 8);

        // Reset with two blocks in flight.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_data = blk[0];
        @(posedge clk); #1;
        a_in_data = blk[1];
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("inflight_valid", a_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", a_out_valid, 0);
        chk("async_rst_data", a_out_data, 0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rel2_ready", a_in_ready, 1);
        a_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            @(negedge clk) chk("no_stale", a_out_valid, 0);
        end
        @(posedge clk); #1;

`ifdef SHIFT_ROWS_PARITY_EN
        chk("par_err_rst", a_par_err, 0);
        a_flip = 16'h0020;
        a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_data = 128'h3052411ee55db4b8f198bfe0ae1127d4;
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_flip = '0;
        @(negedge clk) chk("par_err_set", a_par_err, 1);
        @(posedge clk); #1;
        send_a(128'he598271ef11141b8ae52b4e0305dbfd4, 1, '0, 128'h3052411ee55db4b8f198bfe0ae1127d4);
        chk("par_err_sticky", a_par_err, 1);
        rst_n = 1'b0;
        #1 chk("par_err_clr", a_par_err, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
